rca_pipe_arbiter: RTL and testbench
===================================

Name: rca_pipe_arbiter

Overview:
Round-robin arbiter and tag tracker that shares one pipelined ripple-carry adder (8-bit, LAT-cycle latency, no reset, no stall) among N requesters. Accepts at most one operation per cycle and drives the adder operand inputs. Shifts a requester-ID/valid tag alongside the adder pipeline. Returns each result on a common response bus tagged with the originating requester ID.

Parameters:
N, 4, number of requesters (>=2)
W, 8, operand/sum width; must match adder
LAT, 9, adder latency: operands on add_a/add_b/add_cin in cycle t give result on add_sum/add_cout in cycle t+LAT
IDW, clog2(N), requester ID width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
issue_en  in  1  global enable; 0 blocks new acceptances, in-flight ops continue
req_valid  in  N  per-requester request valid
req_a  in  N*W  packed operand A, requester i at [i*W +: W]
req_b  in  N*W  packed operand B
req_cin  in  N  per-requester carry-in
req_ready  out  N  one-hot-or-zero accept; transfer when req_valid[i]&req_ready[i]
add_a  out  W  operand A to adder (registered)
add_b  out  W  operand B to adder (registered)
add_cin  out  1  carry-in to adder (registered)
add_sum  in  W  adder sum
add_cout  in  1  adder carry-out
rsp_valid  out  1  response valid, single-cycle pulse per op, no backpressure
rsp_id  out  IDW  requester ID of response
rsp_sum  out  W  result sum
rsp_cout  out  1  result carry-out
in_flight  out  clog2(LAT+3)  accepted ops not yet responded
busy  out  1  in_flight != 0

Behaviour:
- Reset: req_ready=0 during rst; add_a=0, add_b=0, add_cin=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, in_flight=0, busy=0; RR pointer=0; all tag valids cleared.
- Arbitration: combinational. Scan from pointer upward modulo N; first i with req_valid[i] wins. req_ready[i]=issue_en & win[i]. At most one ready bit high. Ready does not depend on ready of others.
- On accept of i: pointer <= (i+1) mod N. No accept: pointer holds.
- Accept at edge ending cycle t: add_a/add_b/add_cin hold that op's operands in cycle t+1. Tag {valid=1,id=i} enters the tag pipe. No accept: operand regs hold previous values; tag valid=0.
- Tag pipe length LAT: tag is aligned so add_sum in cycle t+1+LAT is paired with it. Response registered: rsp_valid=1, rsp_id, rsp_sum, rsp_cout in cycle t+2+LAT. Total accept-to-response = LAT+2 = 11 cycles at default.
- rsp_valid is 0 whenever the aligned tag is invalid. rsp_sum/rsp_cout/rsp_id hold their last values when rsp_valid=0.
- Throughput: one accept per cycle; responses return in acceptance order, back-to-back.
- in_flight: +1 on accept, -1 on rsp_valid, unchanged on both; max LAT+2, never wraps.
- Adder pipeline has no reset; garbage after reset is masked by cleared tag valids.
- Reset mid-operation: all in-flight ops are dropped. No rsp_valid for them ever. in_flight=0 next cycle.
- issue_en low: req_ready=0 and pointer holds; pipeline drains normally.
- Requester contract: hold req_valid and operands stable until accepted (bench assertion).
- Widths: sum = (a+b+cin) mod 2^W; cout = bit W of the full sum.

Test Plan:
- Single op: requester 1, a=0x5A, b=0x33, cin=1, accepted at cycle 0 -> rsp_valid only in cycle 11, rsp_id=1, rsp_sum=0x8E, rsp_cout=0; in_flight 1 during cycles 1-11, 0 after.
- Overflow: requester 3, a=0xFF, b=0x01, cin=0 -> rsp_sum=0x00, rsp_cout=1. Also a=0xFF, b=0xFF, cin=1 -> 0xFF, cout=1.
- Full contention: all 4 requesters valid continuously with distinct operands -> grants 0,1,2,3,0,... one per cycle. After 11-cycle fill, rsp_valid continuous with ids 0,1,2,3,... and correct sums. in_flight saturates at 11.
- Pointer fairness: grant to 2, then only 0 and 3 valid -> 3 granted next, then 0.
- issue_en drop: 5 ops accepted, issue_en=0 with requests pending -> req_ready=0. All 5 responses still delivered; busy falls the cycle after the last response.
- Reset mid-flight: 6 ops in flight, rst for 1 cycle -> no rsp_valid from them; in_flight=0, pointer=0. A new op after reset completes correctly in 11 cycles.

Source files
------------

// File: rtl/rca_pipe_arbiter.sv
// Round-robin front end for one shared pipelined ripple-carry adder. Grants one
// requester per cycle, registers its operands onto the adder inputs, carries a
// requester tag alongside the adder pipeline and returns tagged results.
module rca_pipe_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 9,
    parameter int unsigned IDW = $clog2(N),
    parameter int unsigned CW  = $clog2(LAT + 3)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_en,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_cin,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    output logic           add_cin,
    input  logic [W-1:0]   add_sum,
    input  logic           add_cout,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_sum,
    output logic           rsp_cout,
    output logic [CW-1:0]  in_flight,
    output logic           busy
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_next;
    logic [N-1:0]   win;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    int unsigned    pos;
    logic           found;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_cin;
    // Entry 0 lines up with add_a/add_b; entry LAT lines up with add_sum.
    logic [LAT:0]   tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT+1];

    // Rotating-priority scan: first valid requester at or above the pointer wins.
    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        cand   = '0;
        pos    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IDW'(pos);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Ready is gated here so a reset cycle or a disabled issue never transfers.
    assign accept    = issue_en && !rst && found;
    assign req_ready = accept ? win : '0;
    assign busy      = (in_flight != '0);

    // Operand mux for the winner and the pointer value that follows it.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_cin  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_cin = req_cin[i];
            end
        end
        if (32'(win_id) == N - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_id + IDW'(1);
        end
    end

    // Pointer and adder operand registers; operands hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (accept) begin
            ptr_q   <= ptr_next;
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_cin <= sel_cin;
        end
    end

    // Tag valid pipe; clearing it on reset masks the unreset adder contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[LAT-1:0], accept};
        end
    end

    // Tag IDs only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= win_id;
        for (int k = 1; k <= LAT; k++) begin
            tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    // Registered response; data fields hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            rsp_valid <= tag_vld_q[LAT];
            if (tag_vld_q[LAT]) begin
                rsp_id   <= tag_id_q[LAT];
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
            end
        end
    end

    // Outstanding-operation count: up on accept, down on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({accept, rsp_valid})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_pipe_arbiter.sv
// Bench for rca_pipe_arbiter: behavioural adder pipeline, queue-based reference
// model checked every cycle, directed scenarios with literal expectations and a
// randomized phase.
module tb_rca_pipe_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 9;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic           clk;
    logic           rst;
    logic           issue_en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [CW-1:0]  in_flight;
    logic           busy;

    rca_pipe_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_en  (issue_en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .in_flight (in_flight),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared adder: LAT-stage pipeline, no reset.
    logic [W:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum  = apipe[LAT-1][W-1:0];
    assign add_cout = apipe[LAT-1][W];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected responses as a queue of (due cycle, id, sum, cout).
    typedef struct {
        int due;
        int id;
        int sum;
        int cout;
    } exp_t;

    exp_t         q[$];
    int           ptr_m = 0;
    int           m_a = 0, m_b = 0, m_cin = 0;
    int           last_id = 0, last_sum = 0, last_cout = 0;
    bit           armed = 0;
    bit           m_acc = 0;
    int           m_acc_id = 0;

    initial begin : compare
        bit           acc;
        bit           due;
        int           acc_id, idx, s, e_id, e_sum, e_cout;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            acc = 0; acc_id = 0; exp_rdy = '0;
            if (issue_en && !rst) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (!acc && req_valid[idx]) begin
                        acc = 1; acc_id = idx; exp_rdy[idx] = 1'b1;
                    end
                end
            end
            if (armed) begin
                due = (q.size() > 0) && (q[0].due == cyc);
                if (due) begin
                    e_id = q[0].id; e_sum = q[0].sum; e_cout = q[0].cout;
                end else begin
                    e_id = last_id; e_sum = last_sum; e_cout = last_cout;
                end
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("add_a", 32'(add_a), m_a);
                chk("add_b", 32'(add_b), m_b);
                chk("add_cin", 32'(add_cin), m_cin);
                chk("rsp_valid", 32'(rsp_valid), 32'(due));
                chk("rsp_id", 32'(rsp_id), e_id);
                chk("rsp_sum", 32'(rsp_sum), e_sum);
                chk("rsp_cout", 32'(rsp_cout), e_cout);
                chk("in_flight", 32'(in_flight), q.size());
                chk("busy", 32'(busy), 32'(q.size() != 0));
                if (!rst) begin
                    if (due) begin
                        last_id = e_id; last_sum = e_sum; last_cout = e_cout;
                        void'(q.pop_front());
                    end
                    if (acc) begin
                        m_a   = int'(req_a[acc_id*W +: W]);
                        m_b   = int'(req_b[acc_id*W +: W]);
                        m_cin = int'(req_cin[acc_id]);
                        s     = m_a + m_b + m_cin;
                        q.push_back('{cyc + LAT + 2, acc_id, s % 256, s / 256});
                        ptr_m = (acc_id + 1) % N;
                    end
                end
            end
            if (rst) begin
                armed = 1;
                q.delete();
                ptr_m = 0; m_a = 0; m_b = 0; m_cin = 0;
                last_id = 0; last_sum = 0; last_cout = 0;
            end
            m_acc    = acc;
            m_acc_id = acc_id;
            cyc++;
        end
    end

    // Advance one cycle and withdraw the request accepted in the cycle just ended.
    task automatic step();
        @(posedge clk);
        #1;
        if (m_acc) req_valid[m_acc_id] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_valid[i]    = 1'b1;
    endtask

    task automatic refill(input int salt);
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) set_req(i, 8'($urandom), 8'(salt * 7 + i), 1'($urandom));
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 100) begin
            step();
            k++;
        end
        chk("drain_bound", 32'(k < 100), 1);
    endtask

    // Single op with literal expectations; returns one cycle after its response.
    task automatic directed_op(input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic [7:0] es, input logic ec);
        int           k;
        logic [N-1:0] exp_g;
        set_req(id, a, b, c);
        exp_g     = '0;
        exp_g[id] = 1'b1;
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'(exp_g));
        step();
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("in_flight_first", 32'(in_flight), 1);
            if (rsp_valid === 1'b1) break;
            step();
        end
        chk("latency", k, LAT + 2);
        chk("op_id", 32'(rsp_id), id);
        chk("op_sum", 32'(rsp_sum), 32'(es));
        chk("op_cout", 32'(rsp_cout), 32'(ec));
        step();
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not finish (checks %0d)", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt;
        rst = 1'b1; issue_en = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_flight", 32'(in_flight), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_add_a", 32'(add_a), 0);
        step();

        issue_en = 1'b1;
        directed_op(1, 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
        @(negedge clk);
        chk("single_in_flight_after", 32'(in_flight), 0);
        chk("single_busy_after", 32'(busy), 0);
        step();
        directed_op(3, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        directed_op(3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        drain();

        // Full contention from pointer 0.
        refill(0);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (c == 20) chk("in_flight_sat", 32'(in_flight), LAT + 2);
            step();
            if (c < 23) refill(c + 1);
        end
        req_valid = '0;
        drain();

        // Pointer fairness.
        set_req(2, 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        chk("fair_g2", 32'(req_ready), 32'h4);
        step();
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(3, 8'h03, 8'h04, 1'b1);
        @(negedge clk);
        chk("fair_g3", 32'(req_ready), 32'h8);
        step();
        @(negedge clk);
        chk("fair_g0", 32'(req_ready), 32'h1);
        step();
        drain();

        // issue_en drop after five accepts.
        refill(40);
        repeat (5) begin
            step();
            refill(41);
        end
        issue_en = 1'b0;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < 3) chk("disabled_ready", 32'(req_ready), 0);
            if (rsp_valid === 1'b1) cnt++;
            step();
        end
        chk("drop_rsp_count", cnt, 5);
        chk("drop_busy_end", 32'(busy), 0);
        req_valid = '0;

        // Reset with six ops in flight.
        issue_en = 1'b1;
        refill(50);
        repeat (6) begin
            step();
            refill(51);
        end
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_flight", 32'(in_flight), 0);
        chk("midrst_busy", 32'(busy), 0);
        step();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) cnt++;
            step();
        end
        chk("midrst_no_rsp", cnt, 0);
        set_req(3, 8'h77, 8'h11, 1'b0);
        directed_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        drain();

        // Randomized traffic with occasional resets and issue gaps.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            issue_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
                            ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
                            1'($urandom));
                end
            end
            step();
        end
        rst = 1'b0;
        issue_en = 1'b0;
        req_valid = '0;
        drain();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
